// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe move controller
//
// Purpose: FSM state encoding, winner codes, player codes and the eight
//          winning-line masks over the row-major 3x3 board (bit i = cell i).
// Ports:   none (package).
package ttt_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_EVAL  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_X    = 2'b01;
   localparam logic [1:0] W_O    = 2'b10;
   localparam logic [1:0] W_DRAW = 2'b11;

   localparam logic PLAYER_X = 1'b0;
   localparam logic PLAYER_O = 1'b1;

   localparam logic [3:0] LAST_CELL = 4'd8;
   localparam logic [3:0] MAX_MOVES = 4'd9;

   // Rows, columns, then the two diagonals.
   localparam logic [8:0] WIN_LINES [8] = '{
      9'h007, 9'h038, 9'h1C0,
      9'h049, 9'h092, 9'h124,
      9'h111, 9'h054
   };

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational three-in-a-row detector
//
// Purpose: reports whether any winning line is fully covered by one player's board.
// Ports:   i_board    [8:0] occupancy of a single player, bit i = cell i
//          o_line_hit       high when at least one of WIN_LINES is complete
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [8:0] i_board,
   output logic       o_line_hit
);

   always_comb begin
      o_line_hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((i_board & WIN_LINES[i]) == WIN_LINES[i]) begin
            o_line_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_move_ctrl.sv
// rtl/ttt_move_ctrl.sv - turn/move controller with legality check and win/draw detect
//
// Purpose: latches a requested cell in IDLE, checks it in CHECK (commit or reject),
//          evaluates the mover's lines in EVAL, and parks in DONE once the game ends.
// Ports:   i_clock, i_reset (sync, active-high), i_new_game (sync clear)
//          i_play, i_pos[3:0]            move request, sampled only in IDLE
//          o_move_accept / o_move_reject one-cycle result pulses
//          o_cell_we[8:0]                one-hot strobe of the committed cell
//          o_board_x / o_board_o [8:0]   registered occupancy
//          o_turn                        player to move (0=X, 1=O)
//          o_winner[1:0]                 00 none, 01 X, 10 O, 11 draw
//          o_game_over                   high while in DONE
module ttt_move_ctrl
   import ttt_pkg::*;
#(
   parameter logic FIRST_PLAYER = PLAYER_X
)(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_new_game,
   input  logic       i_play,
   input  logic [3:0] i_pos,
   output logic       o_move_accept,
   output logic       o_move_reject,
   output logic [8:0] o_cell_we,
   output logic [8:0] o_board_x,
   output logic [8:0] o_board_o,
   output logic       o_turn,
   output logic [1:0] o_winner,
   output logic       o_game_over
);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_pos,     w_pos_nxt;
   logic [8:0] r_board_x, w_board_x_nxt;
   logic [8:0] r_board_o, w_board_o_nxt;
   logic       r_turn,    w_turn_nxt;
   logic [1:0] r_winner,  w_winner_nxt;
   logic [3:0] r_count,   w_count_nxt;
   logic       r_accept,  w_accept_nxt;
   logic       r_reject,  w_reject_nxt;
   logic [8:0] r_cell_we, w_cell_we_nxt;

   logic [8:0] w_pos_onehot;
   logic       w_legal;
   logic       w_line_hit;

   // Out-of-range indices decode to no cell so they can never touch the board.
   always_comb begin
      w_pos_onehot = '0;
      if (r_pos <= LAST_CELL) begin
         w_pos_onehot = 9'b1 << r_pos;
      end
   end

   assign w_legal = (r_pos <= LAST_CELL) && ((w_pos_onehot & (r_board_x | r_board_o)) == '0);

   // In EVAL the board already holds the new move, and r_turn is still the mover.
   ttt_line_check u_line_check (
      .i_board    (r_turn ? r_board_o : r_board_x),
      .o_line_hit (w_line_hit)
   );

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (i_new_game) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (i_play) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_legal ? S_EVAL : S_IDLE;
            S_EVAL:  w_state_nxt = (w_line_hit || (r_count == MAX_MOVES)) ? S_DONE : S_IDLE;
            default: w_state_nxt = S_DONE;
         endcase
      end
   end

   // Output/datapath next values; all of these are registered below.
   always_comb begin
      w_pos_nxt     = r_pos;
      w_board_x_nxt = r_board_x;
      w_board_o_nxt = r_board_o;
      w_turn_nxt    = r_turn;
      w_winner_nxt  = r_winner;
      w_count_nxt   = r_count;
      w_accept_nxt  = 1'b0;
      w_reject_nxt  = 1'b0;
      w_cell_we_nxt = '0;
      if (i_new_game) begin
         w_pos_nxt     = '0;
         w_board_x_nxt = '0;
         w_board_o_nxt = '0;
         w_turn_nxt    = FIRST_PLAYER;
         w_winner_nxt  = W_NONE;
         w_count_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_play) w_pos_nxt = i_pos;
            end
            S_CHECK: begin
               if (w_legal) begin
                  if (r_turn == PLAYER_O) w_board_o_nxt = r_board_o | w_pos_onehot;
                  else                    w_board_x_nxt = r_board_x | w_pos_onehot;
                  w_cell_we_nxt = w_pos_onehot;
                  w_accept_nxt  = 1'b1;
                  w_count_nxt   = r_count + 4'd1;
               end else begin
                  w_reject_nxt  = 1'b1;
               end
            end
            S_EVAL: begin
               // A completed line outranks the full-board draw on move nine.
               if (w_line_hit)                  w_winner_nxt = (r_turn == PLAYER_O) ? W_O : W_X;
               else if (r_count == MAX_MOVES)   w_winner_nxt = W_DRAW;
               else                             w_turn_nxt   = ~r_turn;
            end
            default: begin
               if (i_play) w_reject_nxt = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pos     <= '0;
         r_board_x <= '0;
         r_board_o <= '0;
         r_turn    <= FIRST_PLAYER;
         r_winner  <= W_NONE;
         r_count   <= '0;
         r_accept  <= 1'b0;
         r_reject  <= 1'b0;
         r_cell_we <= '0;
      end else begin
         r_pos     <= w_pos_nxt;
         r_board_x <= w_board_x_nxt;
         r_board_o <= w_board_o_nxt;
         r_turn    <= w_turn_nxt;
         r_winner  <= w_winner_nxt;
         r_count   <= w_count_nxt;
         r_accept  <= w_accept_nxt;
         r_reject  <= w_reject_nxt;
         r_cell_we <= w_cell_we_nxt;
      end
   end

   assign o_move_accept = r_accept;
   assign o_move_reject = r_reject;
   assign o_cell_we     = r_cell_we;
   assign o_board_x     = r_board_x;
   assign o_board_o     = r_board_o;
   assign o_turn        = r_turn;
   assign o_winner      = r_winner;
   assign o_game_over   = (r_state == S_DONE);

endmodule
